// File: rtl/tpu_top.sv
// tpu_top: 4x4 output-stationary systolic matrix multiplier computing C = A x B
// from internal word-addressed global buffers into an output global buffer.
module tpu_gbuff #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] gbuff [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) gbuff[addr] <= wdata;
      rdata <= gbuff[addr];
   end
endmodule

module tpu_top #(
   parameter int DATA_W = 8,
   parameter int WORD_W = 32,
   parameter int ADDR_W = 8,
   parameter int ARR    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] m,
   input  logic [3:0] k,
   input  logic [3:0] n,
   output logic       done
);
   typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, WRITE, DONE} state_t;

   state_t     state_q;
   logic [3:0] m_q, k_q, n_q;
   logic [1:0] tr_q, tc_q;
   logic [4:0] cnt_q;
   logic       done_q;

   logic [3:0] m_sub1, n_sub1;
   logic [1:0] tr_last, tc_last, rows_last;
   logic [2:0] w_words;
   logic [4:0] feed_last;
   logic       lane_vld;

   // Tile bounds: tile counts are ceil(x/4); the last row tile may be partial.
   assign m_sub1    = m_q - 4'd1;
   assign n_sub1    = n_q - 4'd1;
   assign tr_last   = m_sub1[3:2];
   assign tc_last   = n_sub1[3:2];
   assign rows_last = (tr_q == tr_last) ? m_sub1[1:0] : 2'd3;
   assign w_words   = {1'b0, tc_last} + 3'd1;
   assign feed_last = {1'b0, k_q} + 5'd5;
   assign lane_vld  = (state_q == FEED) && (cnt_q < {1'b0, k_q});
   assign done      = done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         m_q     <= '0;
         k_q     <= '0;
         n_q     <= '0;
         tr_q    <= '0;
         tc_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               m_q     <= m;
               k_q     <= k;
               n_q     <= n;
               tr_q    <= '0;
               tc_q    <= '0;
               state_q <= LOAD;
            end
            LOAD: begin
               cnt_q   <= '0;
               state_q <= FEED;
            end
            FEED: if (cnt_q == feed_last) begin
               cnt_q   <= '0;
               state_q <= DRAIN;
            end else begin
               cnt_q <= cnt_q + 5'd1;
            end
            DRAIN: state_q <= WRITE;
            WRITE: if (cnt_q[1:0] == rows_last) begin
               cnt_q <= '0;
               if (tc_q == tc_last) begin
                  tc_q <= '0;
                  if (tr_q == tr_last) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     tr_q    <= tr_q + 2'd1;
                     state_q <= LOAD;
                  end
               end else begin
                  tc_q    <= tc_q + 2'd1;
                  state_q <= LOAD;
               end
            end else begin
               cnt_q <= cnt_q + 5'd1;
            end
            DONE: if (!start) begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Reads are issued one cycle ahead: kk=0 in LOAD, kk=f+1 in FEED cycle f.
   logic [ADDR_W-1:0] kk, addr_a, addr_b, addr_out;
   logic [WORD_W-1:0] a_rdata, b_rdata, out_wdata, out_rdata_unused;
   logic              out_we;

   assign kk       = (state_q == FEED) ? ADDR_W'(cnt_q) + ADDR_W'(1) : '0;
   assign addr_a   = ADDR_W'(tr_q) * ADDR_W'(k_q) + kk;
   assign addr_b   = ADDR_W'(tc_q) * ADDR_W'(k_q) + kk;
   assign addr_out = ADDR_W'({tr_q, cnt_q[1:0]}) * ADDR_W'(w_words) + ADDR_W'(tc_q);
   assign out_we   = (state_q == WRITE);

   tpu_gbuff #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) GBUFF_A (
      .clk(clk), .we(1'b0), .addr(addr_a), .wdata('0), .rdata(a_rdata));
   tpu_gbuff #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) GBUFF_B (
      .clk(clk), .we(1'b0), .addr(addr_b), .wdata('0), .rdata(b_rdata));
   tpu_gbuff #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) GBUFF_OUT (
      .clk(clk), .we(out_we), .addr(addr_out), .wdata(out_wdata), .rdata(out_rdata_unused));

   logic [DATA_W-1:0]   a_lane [ARR], b_lane [ARR], left_a [ARR], top_b [ARR];
   logic [DATA_W-1:0]   a_sk1_q, a_sk1_d, b_sk1_q, b_sk1_d;
   logic [2*DATA_W-1:0] a_sk2_q, a_sk2_d, b_sk2_q, b_sk2_d;
   logic [3*DATA_W-1:0] a_sk3_q, a_sk3_d, b_sk3_q, b_sk3_d;
   logic [DATA_W-1:0]   a_in [ARR][ARR], b_in [ARR][ARR];
   logic [DATA_W-1:0]   acc_q [ARR][ARR], acc_d [ARR][ARR];
   logic [DATA_W-1:0]   a_q [ARR][ARR-1], a_d [ARR][ARR-1];
   logic [DATA_W-1:0]   b_q [ARR-1][ARR], b_d [ARR-1][ARR];

   // Row i / column i is delayed i cycles so matching kk meet at each PE.
   always_comb begin
      for (int i = 0; i < ARR; i++) begin
         a_lane[i] = lane_vld ? a_rdata[DATA_W*i +: DATA_W] : '0;
         b_lane[i] = lane_vld ? b_rdata[DATA_W*i +: DATA_W] : '0;
      end
      left_a[0] = a_lane[0];
      left_a[1] = a_sk1_q;
      left_a[2] = a_sk2_q[2*DATA_W-1 -: DATA_W];
      left_a[3] = a_sk3_q[3*DATA_W-1 -: DATA_W];
      top_b[0]  = b_lane[0];
      top_b[1]  = b_sk1_q;
      top_b[2]  = b_sk2_q[2*DATA_W-1 -: DATA_W];
      top_b[3]  = b_sk3_q[3*DATA_W-1 -: DATA_W];
   end

   always_comb begin
      a_sk1_d = a_sk1_q;
      a_sk2_d = a_sk2_q;
      a_sk3_d = a_sk3_q;
      b_sk1_d = b_sk1_q;
      b_sk2_d = b_sk2_q;
      b_sk3_d = b_sk3_q;
      if (state_q == LOAD) begin
         a_sk1_d = '0;
         a_sk2_d = '0;
         a_sk3_d = '0;
         b_sk1_d = '0;
         b_sk2_d = '0;
         b_sk3_d = '0;
      end else if (state_q == FEED) begin
         a_sk1_d = a_lane[1];
         a_sk2_d = {a_sk2_q[DATA_W-1:0], a_lane[2]};
         a_sk3_d = {a_sk3_q[2*DATA_W-1:0], a_lane[3]};
         b_sk1_d = b_lane[1];
         b_sk2_d = {b_sk2_q[DATA_W-1:0], b_lane[2]};
         b_sk3_d = {b_sk3_q[2*DATA_W-1:0], b_lane[3]};
      end
   end

   // The 8-bit running sum equals the low byte of the full sum of products.
   always_comb begin
      for (int i = 0; i < ARR; i++) begin
         a_in[i][0] = left_a[i];
         b_in[0][i] = top_b[i];
         for (int j = 1; j < ARR; j++) begin
            a_in[i][j] = a_q[i][j-1];
            b_in[j][i] = b_q[j-1][i];
         end
      end
      for (int i = 0; i < ARR; i++) begin
         for (int j = 0; j < ARR; j++) begin
            acc_d[i][j] = acc_q[i][j];
            if (state_q == LOAD) acc_d[i][j] = '0;
            else if (state_q == FEED) acc_d[i][j] = acc_q[i][j] + a_in[i][j] * b_in[i][j];
         end
         for (int j = 0; j < ARR-1; j++) begin
            a_d[i][j] = a_q[i][j];
            b_d[j][i] = b_q[j][i];
            if (state_q == LOAD) begin
               a_d[i][j] = '0;
               b_d[j][i] = '0;
            end else if (state_q == FEED) begin
               a_d[i][j] = a_in[i][j];
               b_d[j][i] = b_in[j][i];
            end
         end
      end
   end

   always_comb begin
      logic [3:0] col;
      out_wdata = '0;
      for (int j = 0; j < ARR; j++) begin
         col = {tc_q, 2'(j)};
         if (col < n_q) out_wdata[DATA_W*j +: DATA_W] = acc_q[cnt_q[1:0]][j];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_sk1_q <= '0;
         a_sk2_q <= '0;
         a_sk3_q <= '0;
         b_sk1_q <= '0;
         b_sk2_q <= '0;
         b_sk3_q <= '0;
         for (int i = 0; i < ARR; i++) begin
            for (int j = 0; j < ARR; j++) acc_q[i][j] <= '0;
            for (int j = 0; j < ARR-1; j++) begin
               a_q[i][j] <= '0;
               b_q[j][i] <= '0;
            end
         end
      end else begin
         a_sk1_q <= a_sk1_d;
         a_sk2_q <= a_sk2_d;
         a_sk3_q <= a_sk3_d;
         b_sk1_q <= b_sk1_d;
         b_sk2_q <= b_sk2_d;
         b_sk3_q <= b_sk3_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end
endmodule

// File: tb/tb_tpu_top.sv
// Self-checking bench for tpu_top: a matrix-level model computes the OUT image
// and done behaviour; a per-cycle monitor checks the done level.
module tb_tpu_top;
   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] m, k, n;
   logic       done;

   always #5 clk = ~clk;

   tpu_top dut (.clk(clk), .rst(rst), .start(start), .m(m), .k(k), .n(n), .done(done));

   int          vectors = 0;
   int          miscompares = 0;
   int          mat_a [12][15];
   int          mat_b [15][12];
   logic [31:0] out_img [256];
   logic [31:0] exp_q [$];
   logic        chk_en = 1'b0;
   logic        exp_done = 1'b0;
   logic [31:0] ident_exp [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // done level monitor, sampled 3 time units after each rising edge
   always @(posedge clk) begin
      #3;
      if (chk_en) check("done_level", {31'b0, done}, {31'b0, exp_done});
   end

   task automatic fill_out(input int seed);
      for (int i = 0; i < 256; i++) begin
         out_img[i] = 32'hC0000000 | (32'(seed) << 16) | 32'(i);
         dut.GBUFF_OUT.gbuff[i] <= out_img[i];
      end
   endtask

   task automatic check_out(input string name);
      for (int i = 0; i < 256; i++) exp_q.push_back(out_img[i]);
      for (int i = 0; i < 256; i++)
         check($sformatf("%s[%0d]", name, i), dut.GBUFF_OUT.gbuff[i], exp_q.pop_front());
   endtask

   // mode 0 random, 1 identity/ramp, 2 all 0xFF, 3 A=1 B=2
   task automatic set_data(input int mode);
      for (int r = 0; r < 12; r++)
         for (int c = 0; c < 15; c++) begin
            case (mode)
               1:       mat_a[r][c] = (r == c) ? 1 : 0;
               2:       mat_a[r][c] = 255;
               3:       mat_a[r][c] = 1;
               default: mat_a[r][c] = int'($urandom_range(0, 255));
            endcase
            case (mode)
               1:       mat_b[c][r] = 4 * c + r;
               2:       mat_b[c][r] = 255;
               3:       mat_b[c][r] = 2;
               default: mat_b[c][r] = int'($urandom_range(0, 255));
            endcase
         end
   endtask

   // Writes A/B buffers in tile layout and updates the expected OUT image.
   task automatic load_job(input int mm, input int kk_n, input int nn);
      int          tm, tn, s;
      logic [31:0] w;
      tm = (mm + 3) / 4;
      tn = (nn + 3) / 4;
      for (int t = 0; t < 3; t++)
         for (int kk = 0; kk < kk_n; kk++) begin
            if (t < tm) begin
               w = '0;
               for (int j = 0; j < 4; j++)
                  if (4 * t + j < mm) w[8*j +: 8] = 8'(mat_a[4*t+j][kk]);
               dut.GBUFF_A.gbuff[t*kk_n+kk] <= w;
            end
            if (t < tn) begin
               w = '0;
               for (int j = 0; j < 4; j++)
                  if (4 * t + j < nn) w[8*j +: 8] = 8'(mat_b[kk][4*t+j]);
               dut.GBUFF_B.gbuff[t*kk_n+kk] <= w;
            end
         end
      for (int r = 0; r < mm; r++)
         for (int tc = 0; tc < tn; tc++) begin
            w = '0;
            for (int j = 0; j < 4; j++)
               if (4 * tc + j < nn) begin
                  s = 0;
                  for (int kk = 0; kk < kk_n; kk++) s += mat_a[r][kk] * mat_b[kk][4*tc+j];
                  w[8*j +: 8] = 8'(s);
               end
            out_img[r*tn+tc] = w;
         end
   endtask

   // Runs one job and leaves start high with done expected to hold.
   task automatic run_job(input string name, input int mm, input int kk_n, input int nn, input int hold);
      int bound, cyc;
      bound = ((mm + 3) / 4) * ((nn + 3) / 4) * (kk_n + 12) + 4;
      cyc = 0;
      load_job(mm, kk_n, nn);
      @(negedge clk);
      m = 4'(mm);
      k = 4'(kk_n);
      n = 4'(nn);
      start = 1'b1;
      chk_en = 1'b0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            m = 4'($urandom_range(0, 15));
            k = 4'($urandom_range(0, 15));
            n = 4'($urandom_range(0, 15));
         end
         if (done || cyc > bound) break;
      end
      check({name, "_latency"}, {31'b0, done}, 32'd1);
      exp_done = 1'b1;
      chk_en = 1'b1;
      repeat (hold) @(negedge clk);
      check_out(name);
   endtask

   task automatic release_start();
      @(negedge clk);
      start = 1'b0;
      exp_done = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rm, rk, rn;
      rst = 1'b0;
      start = 1'b0;
      m = '0;
      k = '0;
      n = '0;
      fill_out(1);
      repeat (3) @(negedge clk);
      check("reset_done", {31'b0, done}, 32'd0);
      rst = 1'b1;
      exp_done = 1'b0;
      chk_en = 1'b1;
      repeat (20) @(negedge clk);
      check_out("reset_out");

      // identity, then handshake: no rerun while start held, rerun after release
      set_data(1);
      run_job("ident", 4, 4, 4, 2);
      for (int r = 0; r < 4; r++) check("ident_lit", dut.GBUFF_OUT.gbuff[r], ident_exp[r]);
      @(negedge clk);
      dut.GBUFF_OUT.gbuff[0] <= 32'hA5A55A5A;
      out_img[0] = 32'hA5A55A5A;
      repeat (20) @(negedge clk);
      check("no_rerun", dut.GBUFF_OUT.gbuff[0], 32'hA5A55A5A);
      release_start();
      run_job("rerun", 4, 4, 4, 2);
      check("rerun_lit", dut.GBUFF_OUT.gbuff[0], 32'h03020100);
      release_start();

      set_data(2);
      run_job("wrap", 4, 4, 4, 1);
      for (int i = 0; i < 4; i++) check("wrap_lit", dut.GBUFF_OUT.gbuff[i], 32'h04040404);
      release_start();

      set_data(3);
      run_job("nonmult", 5, 3, 9, 1);
      for (int i = 0; i < 15; i++)
         check("nonmult_lit", dut.GBUFF_OUT.gbuff[i], (i % 3 == 2) ? 32'h00000006 : 32'h06060606);
      release_start();

      set_data(0);
      run_job("large", 12, 15, 12, 1);
      release_start();

      for (int t = 0; t < 4; t++) begin
         rm = int'($urandom_range(1, 12));
         rk = int'($urandom_range(1, 15));
         rn = int'($urandom_range(1, 12));
         set_data(0);
         run_job($sformatf("rand%0d", t), rm, rk, rn, 1);
         release_start();
      end

      // reset while done is high must drop done at once
      set_data(0);
      run_job("pre_rst", 3, 2, 5, 2);
      @(negedge clk);
      chk_en = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_async", {31'b0, done}, 32'd0);
      start = 1'b0;
      exp_done = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      fill_out(2);
      chk_en = 1'b1;
      repeat (20) @(negedge clk);
      check_out("after_rst");

      // abort a job midway, then confirm a clean rerun
      set_data(0);
      load_job(12, 15, 12);
      @(negedge clk);
      m = 4'd12;
      k = 4'd15;
      n = 4'd12;
      start = 1'b1;
      chk_en = 1'b0;
      repeat (40) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_done", {31'b0, done}, 32'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      fill_out(3);
      exp_done = 1'b0;
      chk_en = 1'b1;
      repeat (20) @(negedge clk);
      check_out("abort_idle");
      run_job("recover", 12, 15, 12, 1);
      release_start();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
